// File: rtl/dcpu_intc_pkg.sv
// Shared constants for the dcpu interrupt controller register window.
// Word offsets are the values of i_addr[3:1]; offsets 6 and 7 are reserved.
// VECTOR_VALID_BIT marks the "something is active" flag in the VECTOR word.
package dcpu_intc_pkg;

  localparam logic [2:0] OFF_PENDING = 3'd0;
  localparam logic [2:0] OFF_ENABLE  = 3'd1;
  localparam logic [2:0] OFF_EDGE    = 3'd2;
  localparam logic [2:0] OFF_VECTOR  = 3'd3;
  localparam logic [2:0] OFF_RAW     = 3'd4;
  localparam logic [2:0] OFF_SWSET   = 3'd5;

  localparam int VECTOR_VALID_BIT = 15;

endpackage

// File: rtl/dcpu_sync2.sv
// Purpose: two-flop synchroniser for W independent asynchronous lines.
// Latency: an input change is visible on o_q after the second i_clk edge.
// Backpressure: none; free-running sampler.
// Ports: i_clk, i_reset_n (async active-low), i_d (async in), o_q (synchronised out).
module dcpu_sync2 #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dcpu_intc.sv
// Purpose: memory-mapped interrupt controller on the dcpu 16-bit bus.
// Latency: source edge to o_int is 4 edges (2 sync, 1 latch, 1 output reg).
// Backpressure: none; single-cycle writes, combinational side-effect-free reads.
// Ports: i_clk/i_reset_n; bus i_addr/i_dat/i_rw -> o_dat/o_sel;
//        i_src asynchronous requests; o_int registered request to the CPU.
module dcpu_intc
  import dcpu_intc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          N_SRC     = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [15:0]      i_addr,
  input  logic [15:0]      i_dat,
  input  logic             i_rw,
  output logic [15:0]      o_dat,
  output logic             o_sel,
  input  logic [N_SRC-1:0] i_src,
  output logic             o_int
);

  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_enable;
  logic [N_SRC-1:0] r_edge;
  logic [N_SRC-1:0] r_prev;
  logic             r_int;

  logic [N_SRC-1:0] w_s;
  logic [2:0]       w_off;
  logic             w_we;
  logic [N_SRC-1:0] w_wdat;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_swset;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_active;
  logic [3:0]       w_vec_idx;
  logic [15:0]      w_vector;
  logic             w_unused;

  dcpu_sync2 #(.W(N_SRC)) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_src),
    .o_q       (w_s)
  );

  // Word access only: the byte-select bit and data bits above the source
  // count carry no meaning.
  assign w_unused = ^{i_addr[0], i_dat[15:N_SRC]};

  assign o_sel  = (i_addr[15:4] == BASE_ADDR[15:4]);
  assign w_off  = i_addr[3:1];
  assign w_we   = o_sel & ~i_rw;
  assign w_wdat = i_dat[N_SRC-1:0];

  assign w_clr   = (w_we && (w_off == OFF_PENDING)) ? w_wdat : '0;
  assign w_swset = (w_we && (w_off == OFF_SWSET))   ? w_wdat : '0;

  // Edge-mode bits latch on a rising synchronised level, level-mode bits
  // latch every cycle the level is high, so a still-asserted level source
  // re-pends immediately after software clears it.
  assign w_set = (r_edge & w_s & ~r_prev) | (~r_edge & w_s) | w_swset;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_edge    <= '1;
      r_prev    <= '0;
      r_int     <= 1'b0;
    end else begin
      r_prev    <= w_s;
      // Set wins over a clear landing in the same cycle.
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_int     <= |(r_pending & r_enable);
      if (w_we && (w_off == OFF_ENABLE)) begin
        r_enable <= w_wdat;
      end
      if (w_we && (w_off == OFF_EDGE)) begin
        r_edge <= w_wdat;
      end
    end
  end

  assign o_int    = r_int;
  assign w_active = r_pending & r_enable;

  // Lowest active index wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_vec_idx = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_vec_idx = 4'(i);
      end
    end
  end

  always_comb begin
    w_vector                   = 16'h0000;
    w_vector[VECTOR_VALID_BIT] = |w_active;
    w_vector[3:0]              = (|w_active) ? w_vec_idx : 4'd0;
  end

  always_comb begin
    o_dat = 16'h0000;
    if (o_sel) begin
      case (w_off)
        OFF_PENDING: o_dat = 16'(r_pending);
        OFF_ENABLE:  o_dat = 16'(r_enable);
        OFF_EDGE:    o_dat = 16'(r_edge);
        OFF_VECTOR:  o_dat = w_vector;
        OFF_RAW:     o_dat = 16'(w_s);
        default:     o_dat = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_dcpu_intc.sv
module tb_dcpu_intc;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] A_PEND  = BASE + 16'h0;
  localparam logic [15:0] A_EN    = BASE + 16'h2;
  localparam logic [15:0] A_EDGE  = BASE + 16'h4;
  localparam logic [15:0] A_VEC   = BASE + 16'h6;
  localparam logic [15:0] A_RAW   = BASE + 16'h8;
  localparam logic [15:0] A_SWSET = BASE + 16'hA;
  localparam logic [15:0] IDLE    = 16'h0120;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_addr;
  logic [15:0] i_dat;
  logic        i_rw;
  logic [15:0] o_dat;
  logic        o_sel;
  logic [7:0]  i_src;
  logic        o_int;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  dcpu_intc #(.BASE_ADDR(BASE), .N_SRC(8)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_addr    (i_addr),
    .i_dat     (i_dat),
    .i_rw      (i_rw),
    .o_dat     (o_dat),
    .o_sel     (o_sel),
    .i_src     (i_src),
    .o_int     (o_int)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // src_at[k] is i_src as seen at the k-th most recent clock edge; the
  // controller acts on a source two edges after it is sampled.
  logic [7:0] m_pend, m_en, m_edge;
  logic       m_int;
  logic [7:0] src_at [0:2];

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] now_lvl, before_lvl, set_bits, clr_bits;
    logic       wr;
    if (!rst_n) begin
      m_pend = 8'h00; m_en = 8'h00; m_edge = 8'hFF; m_int = 1'b0;
      src_at[0] = 8'h00; src_at[1] = 8'h00; src_at[2] = 8'h00;
    end else begin
      now_lvl    = src_at[1];
      before_lvl = src_at[2];
      wr = (i_addr[15:4] == BASE[15:4]) && !i_rw;
      set_bits = 8'h00;
      clr_bits = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (m_edge[b]) set_bits[b] = now_lvl[b] && !before_lvl[b];
        else           set_bits[b] = now_lvl[b];
      end
      if (wr && i_addr[3:1] == 3'd5) set_bits = set_bits | i_dat[7:0];
      if (wr && i_addr[3:1] == 3'd0) clr_bits = i_dat[7:0];
      m_int  = (m_pend & m_en) != 8'h00;
      m_pend = (m_pend & ~clr_bits) | set_bits;
      if (wr && i_addr[3:1] == 3'd1) m_en   = i_dat[7:0];
      if (wr && i_addr[3:1] == 3'd2) m_edge = i_dat[7:0];
      src_at[2] = src_at[1];
      src_at[1] = src_at[0];
      src_at[0] = i_src;
    end
  end

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    logic [7:0] act;
    logic [15:0] v;
    if (a[15:4] != BASE[15:4]) return 16'h0000;
    case (a[3:1])
      3'd0: return {8'h00, m_pend};
      3'd1: return {8'h00, m_en};
      3'd2: return {8'h00, m_edge};
      3'd3: begin
        act = m_pend & m_en;
        v = 16'h0000;
        for (int b = 7; b >= 0; b--) if (act[b]) v = 16'h8000 + 16'(b);
        return v;
      end
      3'd4: return {8'h00, src_at[1]};
      default: return 16'h0000;
    endcase
  endfunction

  // Every cycle: outputs against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_o_int", {15'h0, o_int}, {15'h0, m_int});
    chk("model_o_sel", {15'h0, o_sel}, {15'h0, (i_addr[15:4] == BASE[15:4])});
    chk("model_o_dat", o_dat, exp_rd(i_addr));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    i_addr = a; i_dat = d; i_rw = 1'b0;
    tick();
    i_rw = 1'b1; i_addr = IDLE; i_dat = 16'h0000;
  endtask

  // Read check consumes one cycle; reads must never disturb state.
  task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    i_addr = a; i_rw = 1'b1;
    #1;
    chk(name, o_dat, exp);
    tick();
    i_addr = IDLE;
  endtask

  initial begin
    rst_n = 1'b0; i_addr = IDLE; i_dat = 16'h0000; i_rw = 1'b1; i_src = 8'h00;
    repeat (2) tick();
    rd_chk("reset_edge", A_EDGE, 16'h00FF);
    chk("reset_int", {15'h0, o_int}, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Edge latency on src[2]
    wr(A_EN, 16'h0004);
    i_src = 8'h04;           // before E0
    tick(); i_src = 8'h00;   // after E0
    tick();                  // after E1
    tick();                  // after E2
    chk("lat_int_E2", {15'h0, o_int}, 16'h0000);
    rd_chk("lat_pend_E2", A_PEND, 16'h0004);   // ends after E3
    chk("lat_int_E3", {15'h0, o_int}, 16'h0001);
    rd_chk("lat_vector", A_VEC, 16'h8002);
    wr(A_PEND, 16'h0004);
    chk("w1c_int_same", {15'h0, o_int}, 16'h0001);
    tick();
    chk("w1c_int_next", {15'h0, o_int}, 16'h0000);

    // Level re-pend on src[0]
    wr(A_EDGE, 16'h0000);
    wr(A_EN, 16'h0001);
    i_src = 8'h01;
    repeat (4) tick();
    wr(A_PEND, 16'h0001);
    rd_chk("level_repend", A_PEND, 16'h0001);
    i_src = 8'h00;
    repeat (3) tick();
    wr(A_PEND, 16'h0001);
    rd_chk("level_clear", A_PEND, 16'h0000);
    rd_chk("level_stay", A_PEND, 16'h0000);
    wr(A_EDGE, 16'h00FF);

    // Priority and mask
    wr(A_EN, 16'h0000);
    wr(A_SWSET, 16'h0030);
    wr(A_EN, 16'h0020);
    rd_chk("prio_masked", A_VEC, 16'h8005);
    wr(A_EN, 16'h00FF);
    rd_chk("prio_lowest", A_VEC, 16'h8004);
    rd_chk("swset_reads0", A_SWSET, 16'h0000);
    wr(A_EN, 16'h0000);
    rd_chk("mask_vector", A_VEC, 16'h0000);
    chk("mask_int", {15'h0, o_int}, 16'h0000);
    rd_chk("mask_pend", A_PEND, 16'h0030);
    wr(A_PEND, 16'h00FF);

    // Rising edge of src[1] meets W1C of bit 1 at the same edge
    i_src = 8'h02;                 // before E0
    tick(); tick();                // after E1
    i_addr = A_PEND; i_dat = 16'h0002; i_rw = 1'b0;
    tick();                        // E2: set and clear together
    i_rw = 1'b1; i_addr = IDLE;
    rd_chk("set_beats_clr", A_PEND, 16'h0002);
    wr(A_PEND, 16'h0002);
    rd_chk("edge_no_repend", A_PEND, 16'h0000);
    i_src = 8'h00;

    // Mode change: high src[3] switched from edge to level
    i_src = 8'h08;
    repeat (4) tick();
    wr(A_PEND, 16'h0008);
    rd_chk("mode_pre", A_PEND, 16'h0000);
    wr(A_EDGE, 16'h00F7);
    rd_chk("mode_same_cycle", A_PEND, 16'h0000);
    rd_chk("mode_level_set", A_PEND, 16'h0008);
    i_src = 8'h00;
    wr(A_EDGE, 16'h00FF);
    repeat (3) tick();
    wr(A_PEND, 16'h00FF);

    // Decode isolation
    for (int k = 0; k < 8; k++) begin
      i_addr = 16'h1000 + 16'(k * 37); i_rw = 1'b1;
      tick();
    end
    i_addr = BASE + 16'h10; #1;
    chk("outside_sel", {15'h0, o_sel}, 16'h0000);
    wr(BASE + 16'h10, 16'hFFFF);
    wr(BASE + 16'h1A, 16'hFFFF);
    wr(BASE + 16'hC, 16'hFFFF);
    wr(BASE + 16'hE, 16'hFFFF);
    rd_chk("reserved_rd", BASE + 16'hC, 16'h0000);
    rd_chk("iso_pend", A_PEND, 16'h0000);
    rd_chk("iso_en", A_EN, 16'h0000);
    wr(A_SWSET, 16'h0081);
    wr(BASE + 16'h1, 16'h0001);
    rd_chk("odd_w1c", A_PEND, 16'h0080);
    wr(BASE + 16'hB, 16'h0040);
    rd_chk("odd_swset", A_PEND, 16'h00C0);

    // RAW shows synchronised levels
    i_src = 8'h05;
    repeat (3) tick();
    rd_chk("raw", A_RAW, 16'h0005);
    i_src = 8'h00;
    repeat (3) tick();

    // Mid-run reset with everything pending and enabled
    wr(A_SWSET, 16'h00FF);
    wr(A_EN, 16'h00FF);
    tick();
    chk("pre_reset_int", {15'h0, o_int}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("async_reset_int", {15'h0, o_int}, 16'h0000);
    rd_chk("rst_pend", A_PEND, 16'h0000);
    rd_chk("rst_en", A_EN, 16'h0000);
    rd_chk("rst_edge", A_EDGE, 16'h00FF);
    rd_chk("rst_vec", A_VEC, 16'h0000);
    rst_n = 1'b1;
    repeat (2) tick();
    rd_chk("post_rst_pend", A_PEND, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
